// File: rtl/pipe_reg_chain_pkg.sv
// Shared helpers for the elastic register pipeline.
// Provides the occupancy-counter width derived from the stage count.
package pipe_reg_chain_pkg;

    // Bits needed to count 0..depth valid stages; never narrower than one bit.
    function automatic int occ_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_reg_chain_stage.sv
// One elastic register stage: holds a valid bit and a data word.
// Latency: one cycle from source to stage output.
// Backpressure: up_ready = stage empty or downstream ready, combinational pass-through.
module pipe_reg_stage #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    input  logic             dn_ready,
    output logic             up_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    assign up_ready = !valid || dn_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= RST_VAL;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (up_ready) begin
            valid <= src_valid;
            // A bubble leaves the old word in place so out_data stays quiet.
            if (src_valid) begin
                data <= src_data;
            end
        end
    end

endmodule

// File: rtl/pipe_reg_chain.sv
// WIDTH-bit, DEPTH-stage elastic register pipeline with flush and occupancy count.
// Latency: DEPTH cycles from input acceptance to out_valid when unstalled.
// Backpressure: ready ripples combinationally from out_ready, bubbles collapse, full rate.
module pipe_reg_chain
    import pipe_reg_chain_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [occ_width(DEPTH)-1:0]  occupancy
);

    localparam int OCC_W = occ_width(DEPTH);

    logic             stg_vld [DEPTH];
    logic [WIDTH-1:0] stg_dat [DEPTH];
    logic             rdy     [DEPTH+1];

    assign rdy[DEPTH] = out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             src_vld;
        logic [WIDTH-1:0] src_dat;

        if (i == 0) begin : g_head
            assign src_vld = in_valid;
            assign src_dat = in_data;
        end else begin : g_body
            assign src_vld = stg_vld[i-1];
            assign src_dat = stg_dat[i-1];
        end

        pipe_reg_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .src_valid (src_vld),
            .src_data  (src_dat),
            .dn_ready  (rdy[i+1]),
            .up_ready  (rdy[i]),
            .valid     (stg_vld[i]),
            .data      (stg_dat[i])
        );
    end

    assign in_ready  = rdy[0] && !flush && rst_n;
    assign out_valid = stg_vld[DEPTH-1];
    assign out_data  = stg_dat[DEPTH-1];

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Tracking transfers equals the popcount of the valids, without an adder tree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy <= '0;
        end else if (flush) begin
            occupancy <= '0;
        end else begin
            occupancy <= occupancy + OCC_W'(in_fire) - OCC_W'(out_fire);
        end
    end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Randomised and directed bench for pipe_reg_chain against a token/position queue model.
module tb_pipe_reg_chain;

    localparam int D = 3;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;

    int total = 0;
    int bad   = 0;

    // Model: each in-flight word is a token with a position 0..D-1 (D-1 = output side).
    int       q_dat[$];
    int       q_pos[$];
    logic [7:0] last_out = 8'h00;

    always #5 clk = ~clk;

    pipe_reg_chain #(
        .WIDTH   (W),
        .DEPTH   (D),
        .RST_VAL ('0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_out_data", {24'b0, out_data}, 0);
        chk("rst_occ", {30'b0, occupancy}, 0);
        chk("rst_in_ready", {31'b0, in_ready}, 0);
        q_dat     = {};
        q_pos     = {};
        last_out  = 8'h00;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive one cycle of inputs, compare outputs to the model, then advance the model.
    task automatic step(input logic iv, input logic [7:0] id, input logic ordy, input logic fl);
        int   np[$];
        int   limit;
        logic slot0_free;
        logic exp_rdy;
        int   n_dat[$];
        int   n_pos[$];

        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        #1;

        // Head advances freely until the output slot; followers may not pass the word ahead.
        limit = D;
        for (int k = 0; k < q_pos.size(); k++) begin
            if (q_pos[k] + 1 < limit) begin
                np.push_back(q_pos[k] + 1);
                limit = q_pos[k] + 1;
            end else if (k == 0 && q_pos[k] == D - 1 && ordy) begin
                np.push_back(-1);
                limit = D;
            end else begin
                np.push_back(q_pos[k]);
                limit = q_pos[k];
            end
        end
        slot0_free = 1'b1;
        foreach (np[k]) if (np[k] == 0) slot0_free = 1'b0;
        exp_rdy = slot0_free && !fl;

        chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
        chk("out_valid", {31'b0, out_valid},
            {31'b0, (q_pos.size() > 0 && q_pos[0] == D - 1)});
        chk("out_data", {24'b0, out_data}, {24'b0, last_out});
        chk("occupancy", {30'b0, occupancy}, q_pos.size());

        if (fl) begin
            q_dat = {};
            q_pos = {};
        end else begin
            for (int k = 0; k < np.size(); k++) begin
                if (np[k] >= 0) begin
                    n_dat.push_back(q_dat[k]);
                    n_pos.push_back(np[k]);
                    if (np[k] == D - 1 && q_pos[k] != D - 1) last_out = 8'(q_dat[k]);
                end
            end
            if (iv && exp_rdy) begin
                n_dat.push_back(int'(id));
                n_pos.push_back(0);
                if (D == 1) last_out = id;
            end
            q_dat = n_dat;
            q_pos = n_pos;
        end
    endtask

    initial begin
        do_reset();

        // Streaming at full rate.
        step(1, 8'h11, 1, 0);
        step(1, 8'h22, 1, 0);
        step(1, 8'h33, 1, 0);
        step(1, 8'h44, 1, 0);
        repeat (5) step(0, 8'h00, 1, 0);

        // Backpressure: three fit, fourth waits, then drain.
        step(1, 8'hA1, 0, 0);
        step(1, 8'hA2, 0, 0);
        step(1, 8'hA3, 0, 0);
        step(1, 8'hA4, 0, 0);
        step(1, 8'hA4, 0, 0);
        chk("bp_full_occ", {30'b0, occupancy}, 3);
        step(1, 8'hA4, 1, 0);
        repeat (5) step(0, 8'h00, 1, 0);

        // Bubble collapse.
        step(1, 8'h05, 0, 0);
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 0);
        step(1, 8'h06, 0, 0);
        step(0, 8'h00, 0, 0);
        chk("bubble_occ", {30'b0, occupancy}, 2);
        repeat (4) step(0, 8'h00, 1, 0);

        // Flush with a simultaneous input attempt.
        step(1, 8'hB1, 0, 0);
        step(1, 8'hB2, 0, 0);
        step(1, 8'hB3, 0, 0);
        step(1, 8'hFF, 0, 1);
        step(0, 8'h00, 1, 0);
        chk("flush_out_valid", {31'b0, out_valid}, 0);
        repeat (3) step(0, 8'h00, 1, 0);

        // Asynchronous reset with two words in flight, then stream again.
        step(1, 8'h31, 0, 0);
        step(1, 8'h32, 0, 0);
        step(0, 8'h00, 0, 0);
        do_reset();
        step(1, 8'h41, 1, 0);
        step(1, 8'h42, 1, 0);
        repeat (5) step(0, 8'h00, 1, 0);

        // Random traffic with occasional flushes.
        for (int c = 0; c < 600; c++) begin
            step(($urandom_range(0, 3) != 0), 8'($urandom),
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 40) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
